// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester, 64-bit round-robin arbiter.
// The optional burst lock (ARB_BURST_LOCK_EN) is used by rr_arbiter64x4.
package arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 64;

  typedef logic [63:0] word_t;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: the first set request at or after ptr (mod 4) wins.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] grant,
  output logic       any
);
  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    grant = ptr;
    any   = |req;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) grant = ptr + 2'(k);
    end
  end
endmodule

// File: rtl/rr_arbiter64x4.sv
// Round-robin arbiter sharing one 64-bit path between four requesters, with one
// registered output beat. Define ARB_BURST_LOCK_EN to hold the grant through req_last.
module rr_arbiter64x4
  import arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  word_t       req_data [3:0],
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ready,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic [1:0]  out_src,
  input  logic        out_ready
);
  // Handshake: a requester beat moves when req_valid[i] && req_ready[i]; the output
  // beat moves when out_valid && out_ready. req_ready is at most one-hot and never
  // looks at req_data.

  arb_state_t  state_q;
  logic [1:0]  ptr_q;
  logic        out_valid_q;
  word_t       out_data_q;
  logic [1:0]  out_src_q;

  logic [3:0]  pick_req;
  logic [1:0]  pick_ptr;
  logic [1:0]  grant;
  logic        any;
  logic        can_accept;
  logic        accept;
  word_t       out_data_d;

  // While locked only the owner (the last accepted source) may be considered.
  always_comb begin
    pick_req = req_valid;
    pick_ptr = ptr_q;
    if (state_q == LOCK) begin
      pick_req = req_valid & (4'b0001 << out_src_q);
      pick_ptr = out_src_q;
    end
  end

  rr_pick4 u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .grant (grant),
    .any   (any)
  );

  assign can_accept = !out_valid_q || out_ready;
  assign accept     = reset && can_accept && any;
  assign req_ready  = accept ? (4'b0001 << grant) : 4'b0000;
  assign out_data_d = req_data[grant];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ARB;
      ptr_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_d;
        out_src_q   <= grant;
`ifdef ARB_BURST_LOCK_EN
        case (state_q)
          ARB: begin
            if (req_last[grant]) ptr_q <= grant + 2'd1;
            else                 state_q <= LOCK;
          end
          LOCK: begin
            if (req_last[grant]) begin
              state_q <= ARB;
              ptr_q   <= grant + 2'd1;
            end
          end
          default: state_q <= ARB;
        endcase
`else
        ptr_q <= grant + 2'd1;
`endif
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifndef ARB_BURST_LOCK_EN
  logic unused_last;
  assign unused_last = ^req_last;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
endmodule

// File: tb/tb_rr_arbiter64x4.sv
// Bench for rr_arbiter64x4: directed vectors with literal expectations plus a
// behavioural model checked every cycle; works with or without ARB_BURST_LOCK_EN.
module tb_rr_arbiter64x4;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_data [3:0];
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic [1:0]  out_src;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  rr_arbiter64x4 dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: state after the most recent posedge
  logic        m_valid  = 1'b0;
  logic [63:0] m_data   = '0;
  int          m_src    = 0;
  int          m_ptr    = 0;
  logic        m_locked = 1'b0;
  int          m_lock   = 0;
  logic [65:0] exp_q [$];

  always @(negedge clk) begin
    logic       can, found;
    int         win;
    logic [3:0] exp_ready;
    logic [65:0] head;
    found = 1'b0;
    win   = 0;
    if (m_locked) begin
      if (req_valid[m_lock]) begin found = 1'b1; win = m_lock; end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (!found && req_valid[(m_ptr + k) % 4]) begin
          found = 1'b1;
          win   = (m_ptr + k) % 4;
        end
      end
    end
    can = !m_valid || out_ready;
    exp_ready = (reset && can && found) ? 4'(1 << win) : 4'b0000;

    chk("model_req_ready", 64'(req_ready), 64'(exp_ready));
    chk("model_out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("model_out_src", 64'(out_src), 64'(m_src));
      chk("model_out_data", out_data, m_data);
    end

    if (!reset) begin
      m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
      m_locked = 1'b0; m_lock = 0;
      exp_q.delete();
    end else begin
      if (m_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 64'(1), 64'(0));
        end else begin
          head = exp_q.pop_front();
          chk("scoreboard_src", 64'(out_src), 64'(head[65:64]));
          chk("scoreboard_data", out_data, head[63:0]);
        end
      end
      if (can && found) begin
        m_valid = 1'b1;
        m_data  = req_data[win];
        m_src   = win;
        exp_q.push_back({2'(win), req_data[win]});
`ifdef ARB_BURST_LOCK_EN
        if (!m_locked && !req_last[win]) begin
          m_locked = 1'b1;
          m_lock   = win;
        end else if (m_locked && req_last[win]) begin
          m_locked = 1'b0;
          m_ptr    = (win + 1) % 4;
        end else if (!m_locked) begin
          m_ptr = (win + 1) % 4;
        end
`else
        m_ptr = (win + 1) % 4;
`endif
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic cyc(input logic [3:0] v, input logic [3:0] l);
    @(posedge clk);
    #1;
    req_valid = v;
    req_last  = l;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [1:0] src);
    @(negedge clk);
    chk({name, "_valid"}, 64'(out_valid), 64'(v));
    if (v) begin
      chk({name, "_src"}, 64'(out_src), 64'(src));
      chk({name, "_data"}, out_data, 64'h1111_0000_0000_0000 | 64'(src));
    end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 4'hF;
    req_last  = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i] = 64'h1111_0000_0000_0000 | 64'(i);

    // reset held with all requesters valid
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_out_data", out_data, 64'(0));
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("first_grant", 64'(req_ready), 64'(4'b0001));

    // round-robin with all four valid
    for (int k = 0; k < 5; k++) begin
      expect_out("rr", 1'b1, 2'(k % 4));
      chk("rr_ready", 64'(req_ready), 64'(4'b0001 << ((k + 1) % 4)));
    end

    // pointer wrap: only 3, then only 0, no bubble
    cyc(4'b1000, 4'hF);
    expect_out("rr_tail", 1'b1, 2'd1);
    chk("wrap_ready3", 64'(req_ready), 64'(4'b1000));
    cyc(4'b0001, 4'hF);
    expect_out("wrap3", 1'b1, 2'd3);
    chk("wrap_ready0", 64'(req_ready), 64'(4'b0001));

    // backpressure: requesters 1 and 2
    cyc(4'b0110, 4'hF);
    expect_out("wrap0", 1'b1, 2'd0);
    chk("bp_ready1", 64'(req_ready), 64'(4'b0010));
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out("bp_hold", 1'b1, 2'd1);
      chk("bp_hold_ready", 64'(req_ready), 64'(0));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(req_ready), 64'(4'b0100));
    cyc(4'b0001, 4'hF);
    expect_out("bp_refill", 1'b1, 2'd2);

    // burst: requester 2 with last=0,(drop),0,1 while requester 0 stays valid
    cyc(4'b0101, 4'b0001);
    expect_out("burst_prime", 1'b1, 2'd0);
    cyc(4'b0001, 4'b0001);
    expect_out("burst_b1", 1'b1, 2'd2);
    cyc(4'b0101, 4'b0001);
`ifdef ARB_BURST_LOCK_EN
    expect_out("burst_drop", 1'b0, 2'd0);
`else
    expect_out("burst_drop", 1'b1, 2'd0);
`endif
    cyc(4'b0101, 4'b0101);
    expect_out("burst_b2", 1'b1, 2'd2);
    cyc(4'b0001, 4'b0101);
`ifdef ARB_BURST_LOCK_EN
    expect_out("burst_b3", 1'b1, 2'd2);
`else
    expect_out("burst_b3", 1'b1, 2'd0);
`endif

    // reset mid-operation while holding a beat (and a lock when enabled)
    cyc(4'b0100, 4'b0000);
    expect_out("burst_after", 1'b1, 2'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    reset     = 1'b0;
    expect_out("pre_reset", 1'b1, 2'd2);
    @(negedge clk);
    chk("mid_reset_valid", 64'(out_valid), 64'(0));
    chk("mid_reset_data", out_data, 64'(0));
    chk("mid_reset_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = 4'b0001;
    req_last  = 4'hF;
    out_ready = 1'b1;
    @(negedge clk);
    chk("lock_released", 64'(req_ready), 64'(4'b0001));

    // model-checked mixed traffic
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      req_valid = 4'($urandom_range(0, 15));
      req_last  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) req_data[i] = {$urandom, $urandom};
    end
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
